// File: rtl/conv2_seq_pkg.sv
// Shared definitions for the conv2 feature-map sequencer.
// Holds the FSM state encoding and the per-channel pixel and window
// counts, both as default constants and as functions so that a
// parameterised instance can derive its own values.
package conv2_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_NEXT   = 3'd4,
        S_DONE   = 3'd5
    } conv_state_t;

    localparam int DEF_WIDTH  = 13;
    localparam int DEF_HEIGHT = 13;
    localparam int WCNT_W     = 16;   // window counter width

    // Pixels read per channel.
    function automatic int pix_per_ch(input int w, input int h);
        return w * h;
    endfunction

    // 3x3 valid windows produced per channel.
    function automatic int win_per_ch(input int w, input int h);
        return (w - 2) * (h - 2);
    endfunction

    localparam int PIX_PER_CH = pix_per_ch(DEF_WIDTH, DEF_HEIGHT);
    localparam int WIN_PER_CH = win_per_ch(DEF_WIDTH, DEF_HEIGHT);

endpackage

// File: rtl/conv2_seq_win_cnt.sv
// Output-window coordinate tracker.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr          return to window (0,0) and zero the count
//   inc          one window accepted this cycle
//   row, col     coordinates of the window currently presented
//   cnt          windows accepted since the last clear
module conv_win_cnt
    import conv2_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [7:0]        row,
    output logic [7:0]        col,
    output logic [WCNT_W-1:0] cnt
);

    localparam logic [7:0] COL_LAST = 8'(WIDTH - 3);
    localparam logic [7:0] ROW_LAST = 8'(HEIGHT - 3);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            row <= '0;
            col <= '0;
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? 8'd0 : row + 8'd1;
            end else begin
                col <= col + 8'd1;
            end
        end
    end

endmodule

// File: rtl/conv2_seq.sv
// Multi-channel feature-map sequencer for a 3x3 convolution.
// For each channel it clears the line buffer, streams WIDTH*HEIGHT
// pixels out of the feature-map RAM into it, qualifies the window
// strobes coming back, and steps to the next channel once all windows
// of the channel have been seen.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             run request (IDLE only)
//   stall             downstream hold, blocks new RAM reads
//   busy, done        run in progress / end-of-run pulse
//   mem_en, mem_addr  RAM read port; mem_rdata returns one cycle later
//   buf_rst_n         line-buffer clear (low one cycle per channel)
//   buf_valid_in      pixel strobe, buf_pixel pixel to the line buffer
//   buf_valid_out     window strobe from the line buffer
//   win_valid         qualified window strobe, with win_row/col/ch
//   ch_done           pulse after the last window of a channel
module conv2_seq
    import conv2_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int NUM_CH = 6,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              buf_rst_n,
    output logic              buf_valid_in,
    output logic [7:0]        buf_pixel,
    input  logic              buf_valid_out,
    output logic              win_valid,
    output logic [7:0]        win_row,
    output logic [7:0]        win_col,
    output logic [7:0]        win_ch,
    output logic              ch_done
);

    localparam int                PIX      = pix_per_ch(WIDTH, HEIGHT);
    localparam logic [ADDR_W-1:0] PIX_A    = ADDR_W'(PIX);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(PIX - 1);
    localparam logic [WCNT_W-1:0] WIN_C    = WCNT_W'(win_per_ch(WIDTH, HEIGHT));
    localparam logic [7:0]        CH_LAST  = 8'(NUM_CH - 1);

    conv_state_t       state, state_nx;
    logic [ADDR_W-1:0] pix;
    logic [ADDR_W-1:0] ch_base;   // ch*PIX kept as a running sum
    logic [7:0]        ch;
    logic [WCNT_W-1:0] win_cnt;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:   if (start) state_nx = S_CLEAR;
            S_CLEAR:  state_nx = S_STREAM;
            S_STREAM: if (!stall && pix == PIX_LAST) state_nx = S_DRAIN;
            // Last pixel lands in the buffer after STREAM, so the final
            // windows always arrive here.
            S_DRAIN:  if (win_cnt == WIN_C) state_nx = S_NEXT;
            S_NEXT:   state_nx = (ch != CH_LAST) ? S_CLEAR : S_DONE;
            S_DONE:   state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        ch_done   = (state == S_NEXT);
        mem_en    = (state == S_STREAM) && !stall;
        win_valid = buf_valid_out && (state == S_STREAM || state == S_DRAIN);
    end

    // Datapath: pixel / channel counters and line-buffer strobes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix          <= '0;
            ch           <= '0;
            ch_base      <= '0;
            buf_valid_in <= 1'b0;
            buf_rst_n    <= 1'b0;
        end else begin
            // Follows mem_en unconditionally, so a read issued just
            // before a stall is still delivered.
            buf_valid_in <= mem_en;
            // Registered from next state so it lines up with CLEAR.
            buf_rst_n    <= (state_nx != S_CLEAR);
            unique case (state)
                S_CLEAR:  pix <= '0;
                // Holds at the last pixel; CLEAR rewinds it.
                S_STREAM: if (!stall && pix != PIX_LAST) pix <= pix + 1'b1;
                S_NEXT: begin
                    if (ch != CH_LAST) begin
                        ch      <= ch + 8'd1;
                        ch_base <= ch_base + PIX_A;
                    end
                end
                S_DONE: begin
                    pix     <= '0;
                    ch      <= '0;
                    ch_base <= '0;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = ch_base + pix;
    assign buf_pixel = mem_rdata;
    assign win_ch    = ch;

    conv_win_cnt #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_win_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == S_CLEAR),
        .inc   (win_valid),
        .row   (win_row),
        .col   (win_col),
        .cnt   (win_cnt)
    );

endmodule

// File: tb/tb_conv2_seq.sv
module tb_conv2_seq;

    localparam int W     = 13;
    localparam int H     = 13;
    localparam int NCH   = 6;
    localparam int AW    = 11;
    localparam int PPC   = W * H;
    localparam int WPC   = (W - 2) * (H - 2);
    localparam int TOTRD = NCH * PPC;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          inject = 1'b0;
    logic          busy, done, mem_en, buf_rst_n, buf_valid_in;
    logic          win_valid, ch_done, buf_valid_out;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'd0;
    logic [7:0]    buf_pixel, win_row, win_col, win_ch;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    conv2_seq #(.WIDTH(W), .HEIGHT(H), .NUM_CH(NCH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .buf_rst_n(buf_rst_n),
        .buf_valid_in(buf_valid_in), .buf_pixel(buf_pixel),
        .buf_valid_out(buf_valid_out), .win_valid(win_valid),
        .win_row(win_row), .win_col(win_col), .win_ch(win_ch),
        .ch_done(ch_done)
    );

    // RAM model: RAM[a] = a[7:0], one-cycle read latency
    always @(posedge clk) if (mem_en) mem_rdata <= mem_addr[7:0];

    // Line-buffer model: a 3x3 window completes on every pixel with
    // row >= 2 and col >= 2; the strobe comes one cycle after the pixel.
    int   lb_cnt = 0;
    logic lb_vo = 1'b0;
    always @(posedge clk) begin
        if (!buf_rst_n) begin
            lb_cnt <= 0;
            lb_vo  <= 1'b0;
        end else begin
            lb_vo <= buf_valid_in && (lb_cnt / W >= 2) && (lb_cnt % W >= 2);
            if (buf_valid_in) lb_cnt <= lb_cnt + 1;
        end
    end
    assign buf_valid_out = lb_vo | inject;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model / monitor: reads must walk addresses 0..TOTRD-1 in
    // order, windows come raster-ordered per channel.
    int   exp_idx = 0, cur_ch = 0, ch_win = 0, prev_addr = 0, last_addr = 0;
    logic prev_en = 1'b0;
    int   tot_reads = 0, tot_win = 0, tot_chd = 0, tot_done = 0, tot_clr = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
            exp_idx = 0; cur_ch = 0; ch_win = 0;
        end else begin
            if (!busy) begin
                exp_idx = 0; cur_ch = 0; ch_win = 0;
            end
            if (mem_en) begin
                chk("rd_addr", int'(mem_addr), exp_idx);
                exp_idx++;
                tot_reads++;
                last_addr = int'(mem_addr);
            end
            if (stall) chk("stall_no_read", int'(mem_en), 0);
            if (buf_valid_in || prev_en) chk("buf_valid_in_delay", int'(buf_valid_in), int'(prev_en));
            if (buf_valid_in) chk("buf_pixel", int'(buf_pixel), prev_addr % 256);
            prev_en   = mem_en;
            prev_addr = int'(mem_addr);
            if (buf_valid_out && !busy) begin
                chk("win_ignored_idle", int'(win_valid), 0);
            end else if (buf_valid_out) begin
                chk("win_valid", int'(win_valid), 1);
                chk("win_row", int'(win_row), ch_win / (W - 2));
                chk("win_col", int'(win_col), ch_win % (W - 2));
                chk("win_ch", int'(win_ch), cur_ch);
                ch_win++;
                tot_win++;
            end else if (win_valid) begin
                chk("win_spurious", int'(win_valid), 0);
            end
            if (ch_done) begin
                chk("ch_windows", ch_win, WPC);
                chk("ch_done_ch", int'(win_ch), cur_ch);
                cur_ch++;
                ch_win = 0;
                tot_chd++;
            end
            if (done) tot_done++;
            if (!buf_rst_n && busy) tot_clr++;
        end
    end

    typedef struct {
        int stall_pct;
        bit extra_start;
        int exp_reads;
        int exp_win;
        int exp_chd;
        int exp_done;
        int exp_clr;
        int exp_last;
    } vec_t;

    vec_t tbl[4];
    int s_rd, s_win, s_chd, s_done, s_clr;

    task automatic snap();
        s_rd = tot_reads; s_win = tot_win; s_chd = tot_chd;
        s_done = tot_done; s_clr = tot_clr;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic drive_until_done(input int stall_pct, input bit extra_start);
        int cyc = 0;
        bit got = 0;
        while (!got && cyc < 8000) begin
            @(posedge clk);
            #1;
            stall = (stall_pct > 0) && ($urandom_range(99) < stall_pct);
            start = extra_start && (cyc == 300 || cyc == 301);
            cyc++;
            @(negedge clk);
            if (done) got = 1;
        end
        stall = 1'b0;
        start = 1'b0;
        chk("run_completes", int'(got), 1);
        @(negedge clk);
        chk("busy_low_after_done", int'(busy), 0);
    endtask

    task automatic check_run(input vec_t v);
        chk("run_reads", tot_reads - s_rd, v.exp_reads);
        chk("run_windows", tot_win - s_win, v.exp_win);
        chk("run_ch_done", tot_chd - s_chd, v.exp_chd);
        chk("run_done", tot_done - s_done, v.exp_done);
        chk("run_buf_clears", tot_clr - s_clr, v.exp_clr);
        chk("run_last_addr", last_addr, v.exp_last);
    endtask

    task automatic wait_addr(input int a, output bit ok);
        int k = 0;
        ok = 0;
        while (!ok && k < 4000) begin
            @(negedge clk);
            if (mem_en && int'(mem_addr) == a) ok = 1;
            k++;
        end
        chk("reach_addr", int'(ok), 1);
    endtask

    initial begin
        bit ok;
        int bvi;
        tbl[0] = '{0,  1'b0, TOTRD, NCH * WPC, NCH, 1, NCH, TOTRD - 1};
        tbl[1] = '{30, 1'b0, TOTRD, NCH * WPC, NCH, 1, NCH, TOTRD - 1};
        tbl[2] = '{0,  1'b1, TOTRD, NCH * WPC, NCH, 1, NCH, TOTRD - 1};
        tbl[3] = '{60, 1'b1, TOTRD, NCH * WPC, NCH, 1, NCH, TOTRD - 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_mem_en", int'(mem_en), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_buf_rst_n", int'(buf_rst_n), 0);
        chk("rst_buf_valid_in", int'(buf_valid_in), 0);
        chk("rst_win", int'({win_valid, ch_done, win_row, win_col, win_ch}), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_buf_rst_n", int'(buf_rst_n), 1);

        // Table-driven full runs
        for (int i = 0; i < 4; i++) begin
            snap();
            pulse_start();
            drive_until_done(tbl[i].stall_pct, tbl[i].extra_start);
            check_run(tbl[i]);
        end

        // Stray window strobe while idle
        @(posedge clk); #1 inject = 1'b1;
        @(negedge clk);
        chk("inject_win_valid", int'(win_valid), 0);
        @(posedge clk); #1 inject = 1'b0;
        @(negedge clk);
        chk("inject_row_col", int'({win_row, win_col}), 0);

        // Five-cycle stall right after pixel 40 of channel 0
        snap();
        pulse_start();
        wait_addr(40, ok);
        @(posedge clk); #1 stall = 1'b1;
        bvi = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_addr_hold", int'(mem_addr), 41);
            chk("stall_mem_en", int'(mem_en), 0);
            bvi += int'(buf_valid_in);
        end
        chk("stall_inflight", bvi, 1);
        @(posedge clk); #1 stall = 1'b0;
        drive_until_done(0, 1'b0);
        check_run(tbl[0]);

        // Reset in the middle of channel 2, pixel 77
        snap();
        pulse_start();
        wait_addr(2 * PPC + 77, ok);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_mem", int'({mem_en, mem_addr}), 0);
        chk("abort_buf", int'({buf_rst_n, buf_valid_in}), 0);
        chk("abort_win", int'({win_valid, ch_done, done, win_row, win_col, win_ch}), 0);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done", tot_done - s_done, 0);
        chk("abort_no_ch_done_left", tot_chd - s_chd, 2);
        snap();
        pulse_start();
        drive_until_done(0, 1'b0);
        check_run(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
